// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: default widths (the same
// values the caches use), FSM state encoding and requester identifiers.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DFLT = 32;
    localparam int WORD_W_DFLT = 32;
    localparam int LINE_W_DFLT = 128;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Requester identifiers, also used as the grant/last register values
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker. On a tie the requester that was not served
// last wins; a lone request always wins. Purely combinational.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Pick the winner: alternate on a tie, otherwise take whoever asks
    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ_I;
        if (req == 2'b11) begin
            gnt_id = ~last;
        end else if (req[REQ_D]) begin
            gnt_id = REQ_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between the ICache (line reads)
// and the DCache (line reads and word stores). The winning request is
// latched and held on the memory side until mem_ready, and the completion
// is routed back to the winner only.
//
// Handshake: a requester raises *_valid with stable fields and holds them
// until it sees a one-cycle *_ready pulse. On the memory side mem_valid and
// the request fields are registered and constant until a one-cycle
// mem_ready pulse; mem_rdata is only meaningful alongside mem_ready, and
// i_data/d_data are only meaningful alongside the matching ready pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int WORD_W = WORD_W_DFLT,
    parameter int LINE_W = LINE_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [LINE_W-1:0] i_data,
    input  logic              d_valid,
    input  logic              d_for_store,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [LINE_W-1:0] d_data,
    output logic              mem_valid,
    output logic              mem_for_store,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata
);

    logic [0:0]        state;
    logic              grant;
    logic              last;
    logic [ADDR_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;
    logic              lat_for_store;
    logic              gnt_valid;
    logic              gnt_id;
    logic              done;

    rr_pick2 u_pick (
        .req       ({d_valid, i_valid}),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Arbitrate in IDLE, latch the winner, hold it until memory completes
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            grant         <= REQ_I;
            last          <= REQ_I;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_for_store <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        grant <= gnt_id;
                        last  <= gnt_id;
                        state <= ST_BUSY;
                        if (gnt_id == REQ_D) begin
                            lat_addr      <= d_addr;
                            lat_wdata     <= d_wdata;
                            lat_for_store <= d_for_store;
                        end else begin
                            lat_addr      <= i_addr;
                            lat_wdata     <= '0;
                            lat_for_store <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (mem_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // A completion counts only while a transaction is outstanding and not
    // being aborted by reset in the same cycle
    assign done = (state == ST_BUSY) && mem_ready && !rst;

    assign i_ready = done && (grant == REQ_I);
    assign d_ready = done && (grant == REQ_D);
    assign i_data  = mem_rdata;
    assign d_data  = mem_rdata;

    assign mem_valid     = (state == ST_BUSY);
    assign mem_addr      = lat_addr;
    assign mem_wdata     = lat_wdata;
    assign mem_for_store = lat_for_store;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer that shares the single external memory port between the instruction cache (line reads) and the data cache (line refills and single-word write-through stores). It sits between both cache FSMs and the memory/bus adapter. It latches the winning request, holds it stable on the memory side until the memory completes it, and routes the completion pulse and line data back to the winner. Contention is resolved round-robin, so neither cache can starve the other.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- WORD_W, 32, store data width
- LINE_W, 128, cache line width returned by memory

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- i_valid  in  1  ICache line-read request, held until i_ready
- i_addr  in  ADDR_W  ICache request address
- i_ready  out  1  one-cycle completion pulse to ICache
- i_data  out  LINE_W  line data, valid when i_ready=1
- d_valid  in  1  DCache request, held until d_ready
- d_for_store  in  1  1 = word store, 0 = line read
- d_addr  in  ADDR_W  DCache request address
- d_wdata  in  WORD_W  store data
- d_ready  out  1  one-cycle completion pulse to DCache
- d_data  out  LINE_W  line data, valid when d_ready=1 and the request was a read
- mem_valid  out  1  memory request valid
- mem_for_store  out  1  1 = write a word, 0 = read a line
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  WORD_W  memory store data
- mem_ready  in  1  one-cycle memory completion pulse
- mem_rdata  in  LINE_W  line data, valid with mem_ready

## Operation
- Two states: IDLE and BUSY.
- Registers:
  - grant: 0 = I, 1 = D
  - last: last-served requester, reset value 0, so D wins the first tie after reset
  - latched addr, wdata and for_store
- IDLE:
  - Neither valid: stay in IDLE.
  - One valid: grant it.
  - Both valid: grant the requester other than last.
  - On grant: latch the request fields (for_store is forced to 0 for I), set last = winner, go to BUSY.
- BUSY:
  - mem_valid=1, and mem_addr, mem_wdata, mem_for_store come from the latched registers.
  - Requester inputs are ignored until completion.
  - On mem_ready=1: pulse ready to the granted requester only, in the same cycle, then go to IDLE.
- i_data and d_data are both driven combinationally from mem_rdata. Only the ready strobe qualifies them.
- mem_wdata is a don't-care for reads but is still driven from the latch.
- mem_ready while in IDLE is ignored; no ready pulse is produced.
- A requester that drops valid while granted violates the protocol. The transaction still completes and ready is still pulsed.
- Cacheability/IO filtering is done upstream. The arbiter treats every request identically.

## Timing
- Reset values: state=IDLE, mem_valid=0, mem_for_store=0, mem_addr=0, mem_wdata=0, i_ready=0, d_ready=0, last=0.
- A rst asserted mid-transaction aborts it. mem_valid falls at the next edge and no ready pulse is issued.
- Request seen in IDLE at cycle t gives mem_valid=1 from cycle t+1. Arbitration latency is one cycle.
- mem_ready at cycle k:
  - i_ready or d_ready =1 at cycle k, combinationally.
  - mem_valid=0 at k+1, state IDLE.
  - Earliest next grant is decided at k+1, so the next mem_valid is at k+2.
  - Memory therefore sees at least one idle cycle between transactions.
- mem_valid and the latched fields are registered outputs and stay constant throughout BUSY.
- A request arriving while BUSY waits. It is arbitrated in the first IDLE cycle.
- Ready outputs are never asserted for more than one cycle per transaction, and never both in the same cycle.

## Structure
- Shared package or header holds ADDR_W/WORD_W/LINE_W defaults (the same constants used by the caches) and the state encoding localparams.
- One sub-module: rr_pick2.
  - Purely combinational two-way round-robin picker.
  - Inputs: req[1:0], last. Outputs: gnt_valid, gnt_id.
- Everything else lives in mem_port_arbiter.

## Test plan
- Reset, then i_valid=1, i_addr=0x1C000040, mem_ready 3 cycles after mem_valid rises, mem_rdata=0x…DEADBEEF → mem_valid at t+1, mem_addr=0x1C000040, mem_for_store=0, i_ready single pulse carrying the line, d_ready stays 0.
- After reset, i_valid and d_valid rise in the same cycle → D served first. I served next with mem_valid re-rising exactly 2 cycles after the first mem_ready. Repeat the tie: I and D alternate.
- d_valid=1, d_for_store=1, d_addr=0x00000104, d_wdata=0x12345678; d_addr is changed to 0x0 while BUSY → mem_addr/mem_wdata hold 0x104/0x12345678 until mem_ready, then d_ready pulses.
- i_valid held continuously, D store issued during the I transaction → D granted at the first IDLE cycle (last=I). No starvation over 10 back-to-back I requests.
- rst asserted during BUSY, with mem_ready arriving afterward → no ready pulse, mem_valid=0 after one edge, stray mem_ready ignored in IDLE.
- mem_ready pulsed while IDLE with no requests → no i_ready/d_ready, state stays IDLE.
